// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-serial overlapping pattern match counter with valid/ready hand-off
// Optional build macro: MATCH_TOTAL_EN (adds clear_total / total_count running total)
module pattern_scan_ctrl #(
    parameter int WIDTH   = 16,
    parameter int PAT_LEN = 4,
    parameter int COUNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               carry,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] out_count,
    output logic               busy
`ifdef MATCH_TOTAL_EN
    ,
    input  logic               clear_total,
    output logic [15:0]        total_count
`endif
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_word;
    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_out_count;
    logic               r_out_valid;

    logic               w_bit;
    logic [PAT_LEN-1:0] w_hist_new;
    logic [FILL_W-1:0]  w_fill_new;
    logic               w_match;
    logic [COUNT_W-1:0] w_count_new;

    // Next detector step for the bit leaving the shift word this cycle
    always_comb begin
        w_bit       = r_word[WIDTH-1];
        w_hist_new  = {r_hist[PAT_LEN-2:0], w_bit};
        w_fill_new  = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        w_match     = (w_fill_new == FILL_FULL) && (w_hist_new == r_pat);
        w_count_new = (w_match && (r_count != CNT_MAX)) ? r_count + COUNT_W'(1) : r_count;
    end

    // Controller FSM: accept, serialize MSB-first, report the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_pat       <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_bit_cnt   <= '0;
            r_count     <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word    <= in_data;
                        r_pat     <= pattern;
                        r_bit_cnt <= '0;
                        r_count   <= '0;
                        if (!carry) begin
                            r_hist <= '0;
                            r_fill <= '0;
                        end
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        // Aborted scans leave no history behind for the next word
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_word    <= {r_word[WIDTH-2:0], 1'b0};
                        r_hist    <= w_hist_new;
                        r_fill    <= w_fill_new;
                        r_count   <= w_count_new;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            r_out_count <= w_count_new;
                            r_out_valid <= 1'b1;
                            r_state     <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;

`ifdef MATCH_TOTAL_EN
    logic        w_handshake;
    logic [16:0] w_total_sum;
    logic [15:0] r_total;

    assign w_handshake = (r_state == REPORT) && out_ready;
    assign w_total_sum = {1'b0, r_total} + 17'(r_out_count);

    // Running total of reported counts; clear beats a coincident handshake
    always_ff @(posedge clk) begin
        if (rst || clear_total) begin
            r_total <= '0;
        end else if (w_handshake) begin
            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    assign total_count = r_total;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    localparam int WIDTH   = 16;
    localparam int PAT_LEN = 4;
    localparam int COUNT_W = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [PAT_LEN-1:0] pattern;
    logic               carry;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] out_count;
    logic               busy;
`ifdef MATCH_TOTAL_EN
    logic               clear_total;
    logic [15:0]        total_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WIDTH(WIDTH), .PAT_LEN(PAT_LEN), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .pattern    (pattern),
        .carry      (carry),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .busy       (busy)
`ifdef MATCH_TOTAL_EN
        ,
        .clear_total(clear_total),
        .total_count(total_count)
`endif
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single edge, then scramble pattern/carry during the scan
    task automatic start_word(input logic [WIDTH-1:0] d, input logic [PAT_LEN-1:0] p, input logic c);
        in_valid = 1'b1;
        in_data  = d;
        pattern  = p;
        carry    = c;
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        pattern  = ~p;
        carry    = ~c;
    endtask

    // Wait for out_valid (bounded), check latency and count; leaves the DUT in REPORT
    task automatic wait_result(input string tag, input int exp_count);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, WIDTH);
        check({tag, "_count"}, 32'(out_count), exp_count);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic run_word(input string tag, input logic [WIDTH-1:0] d,
                            input logic [PAT_LEN-1:0] p, input logic c, input int exp_count);
        start_word(d, p, c);
        wait_result(tag, exp_count);
        release_result(tag);
    endtask

    initial begin
        int seen_valid;
        int stable_bad;
        logic [COUNT_W-1:0] held;
`ifdef MATCH_TOTAL_EN
        logic [15:0] total_before;
        clear_total = 1'b0;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0; pattern = '0;
        carry = 1'b0; abort = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_busy", busy, 0);

        // 1001 overlapping in 1001001001001001 -> 5 hits
        start_word(16'h9249, 4'b1001, 1'b0);
        check("ovl_busy_shift", {30'd0, busy, in_ready}, 32'd2);
        wait_result("ovl", 5);
        check("ovl_busy_report", busy, 1);
        release_result("ovl");

        // History carried across the word boundary
        run_word("carry_a", 16'h0004, 4'b1001, 1'b0, 0);
        run_word("carry_b", 16'h8000, 4'b1001, 1'b1, 1);
        run_word("nocarry_a", 16'h0004, 4'b1001, 1'b0, 0);
        run_word("nocarry_b", 16'h8000, 4'b1001, 1'b0, 0);

        // Back-pressure: result held, new word refused
        start_word(16'h9249, 4'b1001, 1'b0);
        wait_result("bp", 5);
        held = out_count;
        in_valid = 1'b1; in_data = 16'hFFFF; pattern = 4'b1111; carry = 1'b0;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_count !== held || in_ready) stable_bad++;
        end
        in_valid = 1'b0;
        check("bp_stable", stable_bad, 0);
        release_result("bp");
        check("bp_no_accept", busy, 0);
        run_word("bp_next", 16'h9249, 4'b1001, 1'b0, 5);

        // Abort during the scan of all-ones; next word must see fresh history
        start_word(16'hFFFF, 4'b1111, 1'b0);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {30'd0, busy, in_ready}, 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        check("abort_no_result", seen_valid, 0);
        run_word("abort_fresh", 16'hE000, 4'b1111, 1'b1, 0);

        // Saturation: 13 raw hits clamp to 7
`ifdef MATCH_TOTAL_EN
        total_before = total_count;
`endif
        run_word("sat", 16'h0000, 4'b0000, 1'b0, 7);
`ifdef MATCH_TOTAL_EN
        check("total_inc", total_count, 32'(total_before) + 7);
        clear_total = 1'b1;
        tick();
        clear_total = 1'b0;
        check("total_clear", total_count, 0);
        run_word("sat2", 16'h0000, 4'b0000, 1'b0, 7);
`endif

        // Reset mid-scan discards the partial result and history
        start_word(16'hFFFF, 4'b1111, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check("midrst_count", 32'(out_count), 0);
`ifdef MATCH_TOTAL_EN
        check("midrst_total", total_count, 0);
`endif
        run_word("midrst_fresh", 16'hE000, 4'b1111, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
